// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a time-multiplexed 7-segment bus (segments a..g + per-digit enables).
// Define SEG_ACTIVE_LOW_EN for common-anode (active-low) Segmentos/Anodos; outputs stay active-high.
module seg7_scan_reader #(
  parameter int N_DIG         = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           Segmentos,
  input  logic [N_DIG-1:0]     Anodos,
  output logic [4*N_DIG-1:0]   Digitos,
  output logic [N_DIG-1:0]     Blanco,
  output logic [N_DIG-1:0]     Invalido,
  output logic                 Trama,
  output logic                 Error
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  // Returns {blank, invalid, bcd[3:0]} for a sampled a..g pattern.
  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1111110: seg_decode = 6'b00_0000;
      7'b0110000: seg_decode = 6'b00_0001;
      7'b1101101: seg_decode = 6'b00_0010;
      7'b1111001: seg_decode = 6'b00_0011;
      7'b0110011: seg_decode = 6'b00_0100;
      7'b1011011: seg_decode = 6'b00_0101;
      7'b1011111: seg_decode = 6'b00_0110;
      7'b1110000: seg_decode = 6'b00_0111;
      7'b1111111: seg_decode = 6'b00_1000;
      7'b1110011: seg_decode = 6'b00_1001;
      7'b0000000: seg_decode = 6'b10_1111;
      default:    seg_decode = 6'b01_1111;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [N_DIG-1:0] a);
    is_onehot = (a != '0) && ((a & (a - 1'b1)) == '0);
  endfunction

  function automatic logic is_multihot(input logic [N_DIG-1:0] a);
    is_multihot = (a & (a - 1'b1)) != '0;
  endfunction

  // Stage p0: single input register, polarity normalised here.
  logic [6:0]       seg_p0;
  logic [N_DIG-1:0] an_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0 <= '0;
      an_p0  <= '0;
    end else begin
`ifdef SEG_ACTIVE_LOW_EN
      seg_p0 <= ~Segmentos;
      an_p0  <= ~Anodos;
`else
      seg_p0 <= Segmentos;
      an_p0  <= Anodos;
`endif
    end
  end

  state_t           state;
  logic [N_DIG-1:0] cand_an;
  logic [6:0]       cand_seg;
  logic [CNT_W-1:0] cnt;
  logic [N_DIG-1:0] mask;

  logic       vld_p0;
  logic       multi_p0;
  logic       same_p0;
  logic       load_p0;
  logic       cap_p0;
  logic       done_p0;
  logic [5:0] dec_p0;

  assign vld_p0   = is_onehot(an_p0);
  assign multi_p0 = is_multihot(an_p0);
  assign same_p0  = (an_p0 == cand_an) && (seg_p0 == cand_seg);
  assign load_p0  = vld_p0 && ((state == IDLE) || !same_p0);
  // Capturing always uses the live sample: on a hold it equals the candidate.
  assign cap_p0   = (load_p0 && (STABLE_CYCLES == 1)) ||
                    ((state == COUNT) && same_p0 && (cnt == CNT_LAST));
  assign done_p0  = ((mask | an_p0) == '1) && ((mask & an_p0) == '0);
  assign dec_p0   = seg_decode(seg_p0);

  // Stage p1: tracking FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cand_an  <= '0;
      cand_seg <= '0;
      cnt      <= '0;
      mask     <= '0;
      Digitos  <= '1;
      Blanco   <= '1;
      Invalido <= '0;
      Trama    <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Trama <= 1'b0;
      Error <= multi_p0;
      if (cap_p0) begin
        for (int i = 0; i < N_DIG; i++) begin
          if (an_p0[i]) begin
            Digitos[4*i +: 4] <= dec_p0[3:0];
            Blanco[i]         <= dec_p0[5];
            Invalido[i]       <= dec_p0[4];
          end
        end
        if (done_p0) begin
          Trama <= 1'b1;
          mask  <= '0;
        end else begin
          mask <= mask | an_p0;
        end
      end
      if (load_p0) begin
        cand_an  <= an_p0;
        cand_seg <= seg_p0;
        cnt      <= CNT_ONE;
        state    <= (STABLE_CYCLES == 1) ? HELD : COUNT;
      end else if (state != IDLE) begin
        if (!same_p0) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= HELD;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomised and directed bench for seg7_scan_reader against a run-length reference model.
module tb_seg7_scan_reader;

  localparam int ND = 4;
  localparam int SC = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      Segmentos;
  logic [ND-1:0]   Anodos;
  logic [4*ND-1:0] Digitos;
  logic [ND-1:0]   Blanco, Invalido;
  logic            Trama, Error;

  seg7_scan_reader #(.N_DIG(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .Segmentos(Segmentos), .Anodos(Anodos),
    .Digitos(Digitos), .Blanco(Blanco), .Invalido(Invalido),
    .Trama(Trama), .Error(Error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  // Reference model: a capture happens when a run of identical one-hot samples reaches SC exactly.
  int          run;
  logic [6:0]  last_s, samp_s;
  logic [ND-1:0] last_a, samp_a, m_mask, m_blank, m_inv;
  logic [3:0]  m_dig [ND];
  logic        m_trama, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [ND-1:0] a);
`ifdef SEG_ACTIVE_LOW_EN
    Segmentos = ~s;
    Anodos    = ~a;
`else
    Segmentos = s;
    Anodos    = a;
`endif
  endtask

  task automatic model_reset();
    run = 0; last_s = '0; last_a = '0; samp_s = '0; samp_a = '0;
    m_mask = '0; m_blank = '1; m_inv = '0; m_trama = 1'b0; m_err = 1'b0;
    for (int i = 0; i < ND; i++) m_dig[i] = 4'hF;
  endtask

  task automatic model_process(input logic [6:0] s, input logic [ND-1:0] a);
    int slot;
    int val;
    m_err   = ($countones(a) > 1);
    m_trama = 1'b0;
    if ($countones(a) == 1) begin
      if (run > 0 && s == last_s && a == last_a) begin
        if (run < 1000) run++;
      end else begin
        run = 1;
      end
      last_s = s;
      last_a = a;
    end else begin
      run = 0;
    end
    if (run == SC) begin
      slot = 0;
      for (int i = 0; i < ND; i++) if (a[i]) slot = i;
      val = -1;
      for (int d = 0; d < 10; d++) if (seg_tab[d] == s) val = d;
      if (val >= 0) begin
        m_dig[slot] = 4'(val); m_blank[slot] = 1'b0; m_inv[slot] = 1'b0;
      end else if (s == 7'd0) begin
        m_dig[slot] = 4'hF; m_blank[slot] = 1'b1; m_inv[slot] = 1'b0;
      end else begin
        m_dig[slot] = 4'hF; m_blank[slot] = 1'b0; m_inv[slot] = 1'b1;
      end
      if (!m_mask[slot]) begin
        m_mask[slot] = 1'b1;
        if (m_mask == '1) begin
          m_trama = 1'b1;
          m_mask  = '0;
        end
      end
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [ND-1:0] a);
    logic [4*ND-1:0] exp_dig;
    drive(s, a);
    @(posedge clk);
    #1;
    model_process(samp_s, samp_a);
    samp_s = s;
    samp_a = a;
    for (int i = 0; i < ND; i++) exp_dig[4*i +: 4] = m_dig[i];
    chk("digitos", 32'(Digitos), 32'(exp_dig));
    chk("blanco", 32'(Blanco), 32'(m_blank));
    chk("invalido", 32'(Invalido), 32'(m_inv));
    chk("trama", 32'(Trama), 32'(m_trama));
    chk("error", 32'(Error), 32'(m_err));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dig"}, 32'(Digitos), 32'h0000FFFF);
    chk({tag, "_blk"}, 32'(Blanco), 32'hF);
    chk({tag, "_inv"}, 32'(Invalido), 32'h0);
    chk({tag, "_trm"}, 32'(Trama), 32'h0);
    chk({tag, "_err"}, 32'(Error), 32'h0);
  endtask

  int tr_cnt, er_cnt, tr_step, d3_step;

  initial begin
    drive(7'd0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single capture of '5' on anode 0.
    for (int k = 1; k <= 6; k++) begin
      step(7'b1011011, 4'b0001);
      if (k == 3) chk("cap_early", 32'(Digitos[3:0]), 32'hF);
      if (k == 4) begin
        chk("cap_dig0", 32'(Digitos[3:0]), 32'h5);
        chk("cap_blk0", 32'(Blanco[0]), 32'h0);
        chk("cap_others", 32'(Digitos[15:4]), 32'hFFF);
      end
    end

    // Glitch: two cycles only, then no anode.
    repeat (2) step(seg_tab[7], 4'b0010);
    repeat (3) step(7'd0, 4'b0000);
    chk("glitch_dig1", 32'(Digitos[7:4]), 32'hF);

    // Full scan 1,2,3,4.
    tr_cnt = 0; tr_step = -1; d3_step = -2;
    for (int i = 0; i < ND; i++) begin
      for (int k = 0; k < 4; k++) begin
        step(seg_tab[i+1], 4'(1 << i));
        if (Trama) begin tr_cnt++; tr_step = i*4 + k; end
        if (Digitos[15:12] == 4'h4 && d3_step < 0) d3_step = i*4 + k;
      end
    end
    repeat (2) begin
      step(7'd0, 4'b0000);
      if (Trama) tr_cnt++;
    end
    chk("scan_value", 32'(Digitos), 32'h4321);
    chk("scan_trama_cnt", 32'(tr_cnt), 32'd1);
    chk("scan_trama_at_d3", 32'(tr_step), 32'(d3_step));

    // Multi-hot anodes.
    er_cnt = 0;
    repeat (3) begin step(seg_tab[8], 4'b0011); if (Error) er_cnt++; end
    repeat (2) begin step(7'd0, 4'b0000); if (Error) er_cnt++; end
    chk("multihot_err_cycles", 32'(er_cnt), 32'd3);
    chk("multihot_nocap", 32'(Digitos), 32'h4321);

    // Non-decimal pattern, then blank.
    repeat (4) step(7'b0000001, 4'b0100);
    chk("inv_flag2", 32'(Invalido[2]), 32'h1);
    chk("inv_dig2", 32'(Digitos[11:8]), 32'hF);
    repeat (4) step(7'b0000000, 4'b1000);
    chk("blank_flag3", 32'(Blanco[3]), 32'h1);

    // Reset in the middle of a count.
    repeat (3) step(seg_tab[6], 4'b0010);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    model_reset();
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(seg_tab[6], 4'b0010);
      if (k == 3) chk("midreset_recount", 32'(Digitos[7:4]), 32'hF);
      if (k == 4) chk("midreset_cap", 32'(Digitos[7:4]), 32'h6);
    end

    // Randomised bursts.
    for (int b = 0; b < 400; b++) begin
      logic [6:0]    rs;
      logic [ND-1:0] ra;
      int            r, len;
      r = $urandom_range(0, 99);
      if (r < 60)      ra = ND'(1 << $urandom_range(0, ND-1));
      else if (r < 80) ra = '0;
      else             ra = ND'($urandom);
      r = $urandom_range(0, 99);
      if (r < 70)      rs = seg_tab[$urandom_range(0, 9)];
      else if (r < 80) rs = 7'd0;
      else             rs = 7'($urandom);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) step(rs, ra);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
